// File: rtl/compressed_output_packer.sv
// compressed_output_packer: packs 0..IN_BYTES byte groups into OUT_BYTES beats with flush; `PACKER_STATS_EN adds byte/beat counters
module compressed_output_packer #(
    parameter int IN_BYTES    = 16,
    parameter int OUT_BYTES   = 8,
    parameter int DEPTH_BYTES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [IN_BYTES*8-1:0]          in_data,
    input  logic [$clog2(IN_BYTES+1)-1:0]  in_bytes_valid,
    output logic                           in_shift,
    input  logic                           end_of_stream,
    output logic [OUT_BYTES*8-1:0]         out_data,
    output logic [OUT_BYTES-1:0]           out_keep,
    output logic                           out_valid,
    output logic                           out_last,
    input  logic                           out_ready
`ifdef PACKER_STATS_EN
    ,
    output logic [31:0]                    stat_bytes_in,
    output logic [31:0]                    stat_beats_out
`endif
);
    localparam int CW = $clog2(DEPTH_BYTES + 1);
    localparam int PW = $clog2(DEPTH_BYTES);
    localparam int VW = $clog2(IN_BYTES + 1);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN_LAST} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d, push_n, pop_n, take;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]             mem_q [DEPTH_BYTES];
    logic [7:0]             mem_d [DEPTH_BYTES];
    logic [OUT_BYTES*8-1:0] out_data_q, out_data_d;
    logic [OUT_BYTES-1:0]   out_keep_q, out_keep_d;
    logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                   full_word, part_word, load;

    always_comb begin
        full_word   = count_q >= CW'(OUT_BYTES);
        part_word   = state_q == FLUSH && count_q != '0 && !full_word;
        load        = (!out_valid_q || out_ready) && (full_word || part_word);
        take        = full_word ? CW'(OUT_BYTES) : count_q;
        in_shift    = state_q == RUN && in_bytes_valid != '0
                      && CW'(in_bytes_valid) <= CW'(DEPTH_BYTES) - count_q;
        push_n      = in_shift ? CW'(in_bytes_valid) : '0;
        pop_n       = load ? take : '0;
        count_d     = count_q + push_n - pop_n;
        wr_ptr_d    = wr_ptr_q + PW'(push_n);
        rd_ptr_d    = rd_ptr_q + PW'(pop_n);
        mem_d       = mem_q;
        // pointer arithmetic wraps naturally, so a group straddling the end splits itself
        for (int i = 0; i < IN_BYTES; i++)
            if (in_shift && i < int'(in_bytes_valid))
                mem_d[wr_ptr_q + PW'(i)] = in_data[8*i +: 8];
        for (int i = 0; i < OUT_BYTES; i++) begin
            out_data_d[8*i +: 8] = load ? (i < int'(take) ? mem_q[rd_ptr_q + PW'(i)] : 8'h00)
                                        : out_data_q[8*i +: 8];
            out_keep_d[i]        = load ? i < int'(take) : out_keep_q[i];
        end
        out_last_d  = load ? state_q == FLUSH && count_q <= CW'(OUT_BYTES) : out_last_q;
        out_valid_d = load || (out_valid_q && !out_ready);
        // an empty flush still waits for any in-flight beat before returning to RUN
        state_d     = state_q == RUN   ? (end_of_stream ? FLUSH : RUN)
                    : state_q == FLUSH ? ((load && count_q <= CW'(OUT_BYTES)) ? DRAIN_LAST
                                         : (count_q == '0 && (!out_valid_q || out_ready)) ? RUN : FLUSH)
                    : (out_valid_q && out_ready) ? RUN : DRAIN_LAST;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    assert property (@(posedge clk) disable iff (reset) in_bytes_valid <= VW'(IN_BYTES));

`ifdef PACKER_STATS_EN
    logic [31:0] stat_bytes_in_q, stat_bytes_in_d, stat_beats_out_q, stat_beats_out_d;
    logic [32:0] bytes_sum;

    always_comb begin
        bytes_sum        = {1'b0, stat_bytes_in_q} + 33'(push_n);
        stat_bytes_in_d  = bytes_sum[32] ? '1 : bytes_sum[31:0];
        stat_beats_out_d = (out_valid_q && out_ready && stat_beats_out_q != '1)
                         ? stat_beats_out_q + 32'd1 : stat_beats_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_bytes_in_q  <= '0;
            stat_beats_out_q <= '0;
        end else begin
            stat_bytes_in_q  <= stat_bytes_in_d;
            stat_beats_out_q <= stat_beats_out_d;
        end
    end

    assign stat_bytes_in  = stat_bytes_in_q;
    assign stat_beats_out = stat_beats_out_q;
`endif
endmodule

// File: tb/tb_compressed_output_packer.sv
// tb_compressed_output_packer: directed vector table plus hand sequences for backpressure, wrap and reset
module tb_compressed_output_packer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] in_data;
    logic [4:0]   in_bytes_valid = '0;
    logic         in_shift;
    logic         end_of_stream = 1'b0;
    logic [63:0]  out_data;
    logic [7:0]   out_keep;
    logic         out_valid, out_last;
    logic         out_ready = 1'b0;
`ifdef PACKER_STATS_EN
    logic [31:0]  stat_bytes_in, stat_beats_out;
`endif
    logic [7:0]   nb = 8'h01;
    logic [72:0]  beats[$];
    logic [63:0]  held;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    always_comb
        for (int i = 0; i < 16; i++) in_data[8*i +: 8] = nb + 8'(i);

    compressed_output_packer dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_bytes_valid(in_bytes_valid),
        .in_shift(in_shift), .end_of_stream(end_of_stream), .out_data(out_data),
        .out_keep(out_keep), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
`ifdef PACKER_STATS_EN
        , .stat_bytes_in(stat_bytes_in), .stat_beats_out(stat_beats_out)
`endif
    );

    always @(negedge clk)
        if (!reset && out_valid && out_ready) beats.push_back({out_last, out_keep, out_data});

    typedef struct {
        logic [4:0]  n;
        logic        eos, rdy, e_shift, e_valid;
        logic [7:0]  e_keep;
        logic        e_last;
        logic [63:0] e_data;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(input int n, eos, rdy, s, v, input logic [7:0] k, input int l,
                                input logic [63:0] d);
        vec_t t;
        t.n = 5'(n); t.eos = 1'(eos); t.rdy = 1'(rdy); t.e_shift = 1'(s); t.e_valid = 1'(v);
        t.e_keep = k; t.e_last = 1'(l); t.e_data = d;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        logic       s;
        logic [4:0] k;
        s = in_shift;
        k = in_bytes_valid;
        @(posedge clk);
        #1;
        if (s) nb = nb + 8'(k);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_bytes_valid = '0; end_of_stream = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        beats.delete();
        nb = 8'h01;
    endtask

    task automatic wait_beats(input int want);
        for (int c = 0; c < 40 && beats.size() < want; c++) step();
    endtask

    task automatic check_beats(input string nm, input int nbeat, input logic [7:0] start, input int tail);
        chk({nm, "_count"}, 80'(beats.size()), 80'(nbeat));
        for (int b = 0; b < nbeat && b < beats.size(); b++) begin
            int          kb;
            logic [72:0] e;
            kb = (tail != 0 && b == nbeat - 1) ? tail : 8;
            e = '0;
            for (int j = 0; j < kb; j++) begin
                e[8*j +: 8] = start + 8'(8*b + j);
                e[64 + j]   = 1'b1;
            end
            e[72] = tail != 0 && b == nbeat - 1;
            chk($sformatf("%s_beat%0d", nm, b), 80'(beats[b]), 80'(e));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        //         n eos rdy sh v keep  last data
        tv.push_back(mk( 5, 0, 1, 1, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 5, 0, 1, 1, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 0, 0, 1, 0, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 0, 0, 1, 0, 1, 8'hFF, 0, 64'h0807060504030201));
        tv.push_back(mk( 0, 1, 1, 0, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk(16, 0, 1, 0, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk(16, 0, 1, 0, 1, 8'h03, 1, 64'h0000000000000A09));
        tv.push_back(mk(16, 0, 1, 1, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 0, 1, 1, 0, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 0, 0, 1, 0, 1, 8'hFF, 0, 64'h1211100F0E0D0C0B));
        tv.push_back(mk( 0, 0, 1, 0, 1, 8'hFF, 1, 64'h1A19181716151413));
        tv.push_back(mk( 0, 0, 1, 0, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 0, 1, 1, 0, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 3, 0, 1, 0, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 3, 0, 1, 1, 0, 8'h00, 0, 64'h0));
        tv.push_back(mk( 0, 0, 1, 0, 0, 8'h00, 0, 64'h0));

        do_reset();
        #1;
        chk("reset_outputs", 80'({out_valid, out_last, out_keep, out_data}), 80'(0));
        chk("reset_shift", 80'(in_shift), 80'(0));

        foreach (tv[i]) begin
            in_bytes_valid = tv[i].n; end_of_stream = tv[i].eos; out_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d_shift", i), 80'(in_shift), 80'(tv[i].e_shift));
            chk($sformatf("v%0d_valid", i), 80'(out_valid), 80'(tv[i].e_valid));
            if (tv[i].e_valid)
                chk($sformatf("v%0d_beat", i), 80'({out_last, out_keep, out_data}),
                    80'({tv[i].e_last, tv[i].e_keep, tv[i].e_data}));
            step();
        end
        end_of_stream = 1'b0;

        // backpressure: buffer fills, output word holds, then drains in order
        do_reset();
        in_bytes_valid = 5'd16;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("bp_shift%0d", c), 80'(in_shift), 80'(c < 4));
            if (c == 2) held = out_data;
            step();
        end
        #1;
        chk("bp_hold", 80'({out_valid, out_keep, out_data}), 80'({1'b1, 8'hFF, held}));
        chk("bp_first", 80'(held), 80'(64'h0807060504030201));
        in_bytes_valid = '0; out_ready = 1'b1;
        wait_beats(8);
        repeat (3) step();
        check_beats("bp", 8, 8'h01, 0);
        chk("bp_empty", 80'(out_valid), 80'(0));

        // pointer wrap: 60 in, 56 out, 16 more straddle index 63/0, then flush
        do_reset();
        for (int c = 0; c < 4; c++) begin
            in_bytes_valid = (c == 3) ? 5'd12 : 5'd16;
            #1;
            chk($sformatf("wrap_fill%0d", c), 80'(in_shift), 80'(1));
            step();
        end
        in_bytes_valid = '0; out_ready = 1'b1;
        wait_beats(7);
        in_bytes_valid = 5'd16;
        #1;
        chk("wrap_push", 80'(in_shift), 80'(1));
        step();
        in_bytes_valid = '0; end_of_stream = 1'b1;
        step();
        end_of_stream = 1'b0;
        wait_beats(10);
        repeat (2) step();
        check_beats("wrap", 10, 8'h01, 4);

        // reset mid-stream with 30 bytes buffered and a beat pending
        do_reset();
        for (int c = 0; c < 3; c++) begin
            in_bytes_valid = (c == 2) ? 5'd6 : 5'd16;
            #1;
            chk($sformatf("mrst_fill%0d", c), 80'(in_shift), 80'(1));
            step();
        end
        #1;
        chk("mrst_pending", 80'(out_valid), 80'(1));
        reset = 1'b1; in_bytes_valid = 5'd16;
        step();
        reset = 1'b0; in_bytes_valid = '0;
        #1;
        chk("mrst_outputs", 80'({out_valid, out_last, out_keep, out_data}), 80'(0));
        out_ready = 1'b1;
        repeat (4) step();
        chk("mrst_no_beats", 80'(beats.size()), 80'(0));
        nb = 8'h40; in_bytes_valid = 5'd16;
        #1;
        chk("mrst_shift", 80'(in_shift), 80'(1));
        step();
        in_bytes_valid = '0;
        wait_beats(2);
        repeat (2) step();
        check_beats("mrst", 2, 8'h40, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
